iter_shift_ctrl: RTL and testbench

ITER_SHIFT_CTRL -- requirements
Module: iter_shift_ctrl

---
 rtl/iter_shift_pkg.sv | 33 +++
 rtl/shift_step.sv | 19 +
 rtl/iter_shift_ctrl.sv | 95 +++++++++
 tb/tb_iter_shift_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/iter_shift_pkg.sv
// Shared types and constants for the iterative shift/rotate controller.
// Holds op encodings, FSM state enum, data widths and the 1-bit step helper.
package iter_shift_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d, input op_e op);
        logic [WIDTH-1:0] r;
        unique case (op)
            OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
            OP_ROR:  r = {d[0], d[WIDTH-1:1]};
            OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the shifter: one or two bit positions of the
// selected rotate/shift, chosen by the two-step select.
module shift_step
    import iter_shift_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    input  logic             two,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] one;

    always_comb begin
        one = step1(data, op_e'(op));
        nxt = two ? step1(one, op_e'(op)) : one;
    end

endmodule

// File: rtl/iter_shift_ctrl.sv
// Iterative shift/rotate controller: IDLE/SHIFT/DONE FSM, counter and result register.
// Define ITER_SHIFT_DOUBLE_STEP_EN to advance two bit positions per SHIFT cycle.
module iter_shift_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    import iter_shift_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] step_out;
    logic             two;
    logic [AMT_W-1:0] dec;

`ifdef ITER_SHIFT_DOUBLE_STEP_EN
    assign two = (cnt_q >= AMT_W'(2));
`else
    assign two = 1'b0;
`endif
    assign dec = two ? AMT_W'(2) : AMT_W'(1);

    shift_step u_shift_step (
        .data (out_q),
        .op   (op_q),
        .two  (two),
        .nxt  (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            cnt_q <= '0;
            op_q  <= 2'b00;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    out_d   = in;
                    op_d    = op;
                    cnt_d   = amt;
                    state_d = (amt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                out_d = step_out;
                // dec never exceeds cnt_q, so the counter lands exactly on zero
                cnt_d = cnt_q - dec;
                if (cnt_q == dec) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        out  = out_q;
    end

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed self-checking bench for iter_shift_ctrl.
// Expected latency follows ITER_SHIFT_DOUBLE_STEP_EN when that macro is defined.
module tb_iter_shift_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] in_v;
    logic        busy;
    logic        done;
    logic [15:0] out_v;

    int checks = 0;
    int errors = 0;

    iter_shift_ctrl #(
        .WIDTH (16),
        .AMT_W (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .amt   (amt),
        .in    (in_v),
        .busy  (busy),
        .done  (done),
        .out   (out_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input int a);
`ifdef ITER_SHIFT_DOUBLE_STEP_EN
        return (a + 1) / 2 + 1;
`else
        return a + 1;
`endif
    endfunction

    // Called in the cycle right after the accept edge; leaves the bench in the done cycle.
    task automatic wait_done(input string tag, input int lat, input logic [15:0] exp_out);
        int n;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        if (!done) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, "_lat"}, n, lat);
            check_eq({tag, "_out"}, out_v, exp_out);
            check_eq({tag, "_busy"}, busy, 1'b1);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input int a,
                          input logic [15:0] d, input logic [15:0] exp_out);
        start = 1'b1;
        op    = o;
        amt   = a[3:0];
        in_v  = d;
        tick();
        start = 1'b0;
        in_v  = 16'h5A5A;
        wait_done(tag, exp_lat(a), exp_out);
        tick();
        check_eq({tag, "_pulse"}, done, 1'b0);
        check_eq({tag, "_idle"}, busy, 1'b0);
        check_eq({tag, "_hold"}, out_v, exp_out);
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        amt   = 4'd0;
        in_v  = 16'h0000;
        tick();
        tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_out", out_v, 16'h0000);
        rst = 1'b0;
        tick();

        run_op("rol_8001_1", 2'b00, 1, 16'h8001, 16'h0003);
        run_op("sll_0001_15", 2'b01, 15, 16'h0001, 16'h8000);
        run_op("ror_0001_4", 2'b10, 4, 16'h0001, 16'h1000);
        run_op("srl_8000_0", 2'b11, 0, 16'h8000, 16'h8000);
        run_op("sll_00ff_3", 2'b01, 3, 16'h00FF, 16'h07F8);
        run_op("rol_1234_8", 2'b00, 8, 16'h1234, 16'h3412);
        run_op("ror_1234_5", 2'b10, 5, 16'h1234, 16'hA091);

        // Second start arrives mid-operation and stays high through DONE.
        start = 1'b1;
        op    = 2'b11;
        amt   = 4'd3;
        in_v  = 16'hF0F0;
        tick();
        op    = 2'b00;
        amt   = 4'd1;
        in_v  = 16'hFFFF;
        wait_done("srl_ignore", exp_lat(3), 16'h1E1E);
        tick();
        check_eq("srl_ignore_idle", busy, 1'b0);
        check_eq("srl_ignore_out", out_v, 16'h1E1E);
        start = 1'b0;
        tick();
        check_eq("srl_ignore_stay", busy, 1'b0);

        // Abort after three SHIFT cycles.
        start = 1'b1;
        op    = 2'b00;
        amt   = 4'd8;
        in_v  = 16'h1234;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_out", out_v, 16'h0000);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        check_eq("abort_no_done", pulses, 0);

        // start held high: one accept per IDLE cycle.
        start = 1'b1;
        op    = 2'b01;
        amt   = 4'd2;
        in_v  = 16'h0003;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_done($sformatf("b2b%0d", k), exp_lat(2), 16'h000C);
            tick();
            check_eq($sformatf("b2b%0d_pulse", k), done, 1'b0);
            check_eq($sformatf("b2b%0d_idle", k), busy, 1'b0);
            tick();
            check_eq($sformatf("b2b%0d_accept", k), busy, 1'b1);
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_eq("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
